// File: rtl/adxl362_spi_master.sv
// SPI mode-0 master for the ADXL362: command byte, optional address byte and
// 1-16 data bytes under one nCS frame, driven by a start/busy/done handshake.
module adxl362_spi_master #(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 8
) (
  input  logic       clk_16mhz,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] command,
  input  logic [5:0] address,
  input  logic [3:0] byte_count,
  input  logic [7:0] data_write,
  output logic       data_load,
  output logic [7:0] read_data,
  output logic       read_valid,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       SCLK,
  output logic       MOSI,
  output logic       nCS,
  input  logic       MISO
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_SETUP    = 3'd1;
  localparam logic [2:0] ST_SHIFT    = 3'd2;
  localparam logic [2:0] ST_BYTE_END = 3'd3;
  localparam logic [2:0] ST_HOLD     = 3'd4;
  localparam logic [2:0] ST_GAP      = 3'd5;

  localparam logic [1:0] PH_CMD  = 2'd0;
  localparam logic [1:0] PH_ADDR = 2'd1;
  localparam logic [1:0] PH_DATA = 2'd2;

  localparam logic [7:0] CMD_WRITE = 8'h0A;
  localparam logic [7:0] CMD_READ  = 8'h0B;
  localparam logic [7:0] CMD_FIFO  = 8'h0D;

  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);

  logic [2:0]       state;
  logic [1:0]       phase;
  logic [7:0]       cmd_reg;
  logic [5:0]       addr_reg;
  logic [4:0]       count;
  logic [7:0]       wr_buf;
  logic [7:0]       tx_shift;
  logic [7:0]       rx_shift;
  logic [2:0]       bit_cnt;
  logic [DIV_W-1:0] div_cnt;
  logic [GAP_W-1:0] gap_cnt;

  logic cmd_ok;
  logic accept;
  logic div_last;
  logic is_write;

  assign cmd_ok   = (command == CMD_WRITE) || (command == CMD_READ) || (command == CMD_FIFO);
  assign accept   = (state == ST_IDLE) && start && cmd_ok;
  assign div_last = (div_cnt == DIV_LAST);
  assign is_write = (cmd_reg == CMD_WRITE);

  // data_write is captured at the end of the cycle in which data_load is high.
  assign data_load = (accept && command == CMD_WRITE) ||
                     (state == ST_BYTE_END && phase == PH_DATA && is_write);

  // NOTE: all state below is sequential, so every assignment is non-blocking;
  // a blocking assignment here would make later reads see this cycle's update.
  always_ff @(posedge clk_16mhz) begin
    if (rst) begin
      state      <= ST_IDLE;
      phase      <= PH_CMD;
      cmd_reg    <= 8'h00;
      addr_reg   <= 6'd0;
      count      <= 5'd0;
      wr_buf     <= 8'h00;
      tx_shift   <= 8'h00;
      rx_shift   <= 8'h00;
      bit_cnt    <= 3'd0;
      div_cnt    <= '0;
      gap_cnt    <= '0;
      read_data  <= 8'h00;
      read_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      SCLK       <= 1'b0;
      MOSI       <= 1'b0;
      nCS        <= 1'b1;
    end else begin
      done       <= 1'b0;
      err        <= 1'b0;
      read_valid <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (start) begin
            if (cmd_ok) begin
              state    <= ST_SETUP;
              busy     <= 1'b1;
              nCS      <= 1'b0;
              MOSI     <= command[7];
              tx_shift <= command;
              cmd_reg  <= command;
              addr_reg <= address;
              count    <= (byte_count == 4'd0) ? 5'd16 : {1'b0, byte_count};
              phase    <= PH_CMD;
              bit_cnt  <= 3'd0;
              div_cnt  <= '0;
              if (command == CMD_WRITE) wr_buf <= data_write;
            end else begin
              err <= 1'b1;
            end
          end
        end

        ST_SETUP: begin
          if (div_last) begin
            div_cnt  <= '0;
            SCLK     <= 1'b1;
            rx_shift <= {rx_shift[6:0], MISO};
            state    <= ST_SHIFT;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        ST_SHIFT: begin
          if (!div_last) begin
            div_cnt <= div_cnt + 1'b1;
          end else if (!SCLK) begin
            div_cnt  <= '0;
            SCLK     <= 1'b1;
            rx_shift <= {rx_shift[6:0], MISO};
          end else begin
            div_cnt <= '0;
            SCLK    <= 1'b0;
            if (bit_cnt == 3'd7) begin
              bit_cnt <= 3'd0;
              if (phase == PH_DATA) begin
                count <= count - 5'd1;
                if (!is_write) begin
                  read_data  <= rx_shift;
                  read_valid <= 1'b1;
                end
                if (count == 5'd1) begin
                  state <= ST_HOLD;
                  MOSI  <= 1'b0;
                end else begin
                  state <= ST_BYTE_END;
                end
              end else begin
                state <= ST_BYTE_END;
              end
            end else begin
              bit_cnt  <= bit_cnt + 3'd1;
              tx_shift <= {tx_shift[6:0], 1'b0};
              MOSI     <= tx_shift[6];
            end
          end
        end

        // One cycle inside the low half of SCLK: pick the next byte to shift.
        ST_BYTE_END: begin
          div_cnt <= div_cnt + 1'b1;
          state   <= ST_SHIFT;
          if (phase == PH_CMD && cmd_reg != CMD_FIFO) begin
            phase    <= PH_ADDR;
            tx_shift <= {2'b00, addr_reg};
            MOSI     <= 1'b0;
          end else begin
            phase <= PH_DATA;
            if (!is_write) begin
              tx_shift <= 8'h00;
              MOSI     <= 1'b0;
            end else if (phase == PH_DATA) begin
              tx_shift <= data_write;
              MOSI     <= data_write[7];
            end else begin
              tx_shift <= wr_buf;
              MOSI     <= wr_buf[7];
            end
          end
        end

        ST_HOLD: begin
          if (div_last) begin
            nCS     <= 1'b1;
            gap_cnt <= '0;
            state   <= ST_GAP;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        ST_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state <= ST_IDLE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adxl362_spi_master.sv
// Directed bench for adxl362_spi_master with a behavioural ADXL362 slave that
// answers register reads and FIFO reads and records every MOSI byte.
module tb_adxl362_spi_master;

  localparam int H   = 4;
  localparam int GAP = 8;

  logic       clk_16mhz = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] command;
  logic [5:0] address;
  logic [3:0] byte_count;
  logic [7:0] data_write;
  logic       data_load;
  logic [7:0] read_data;
  logic       read_valid;
  logic       busy;
  logic       done;
  logic       err;
  logic       SCLK;
  logic       MOSI;
  logic       nCS;
  logic       MISO;

  adxl362_spi_master #(.CLK_DIV(H), .CS_GAP(GAP)) dut (
    .clk_16mhz  (clk_16mhz),
    .rst        (rst),
    .start      (start),
    .command    (command),
    .address    (address),
    .byte_count (byte_count),
    .data_write (data_write),
    .data_load  (data_load),
    .read_data  (read_data),
    .read_valid (read_valid),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .SCLK       (SCLK),
    .MOSI       (MOSI),
    .nCS        (nCS),
    .MISO       (MISO)
  );

  always #5 clk_16mhz = ~clk_16mhz;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Write bytes handed out in order, one per data_load pulse.
  logic [7:0] wr_vals [16];
  int wr_idx;
  always @(posedge clk_16mhz) begin
    if (start && !busy) wr_idx <= data_load ? 1 : 0;
    else if (data_load) wr_idx <= wr_idx + 1;
  end
  assign data_write = (start && !busy) ? wr_vals[0] : wr_vals[wr_idx[3:0]];

  function automatic logic [7:0] reg_val(input logic [7:0] a);
    case (a)
      8'h00:   return 8'hAD;
      8'h01:   return 8'h1D;
      8'h02:   return 8'hF2;
      8'h03:   return 8'h01;
      default: return a ^ 8'h5A;
    endcase
  endfunction

  logic [7:0] s_cmd, s_addr, s_rx, s_tx;
  int         s_bits;

  function automatic logic [7:0] slave_byte(input int k);
    if (s_cmd == 8'h0B && k >= 2) return reg_val(s_addr + 8'(k - 2));
    if (s_cmd == 8'h0D && k >= 1) return 8'h40 + 8'(k - 1);
    return 8'h00;
  endfunction

  // Frame monitor and slave model, sampled on the falling clk edge.
  int         cyc, ncs_low, dl_cnt, dl_first, done_cnt, done_cyc, err_cnt;
  int         rise_cyc, sclk_first;
  logic [7:0] rv_q [$];
  logic [7:0] mosi_q [$];
  logic       p_ncs  = 1'b1;
  logic       p_sclk = 1'b0;

  always @(negedge clk_16mhz) begin
    if (start && !busy) begin
      cyc = 0; ncs_low = 0; dl_cnt = 0; dl_first = -1; done_cnt = 0;
      done_cyc = -1; err_cnt = 0; rise_cyc = -1; sclk_first = -1;
      rv_q.delete();
    end else begin
      cyc++;
    end
    if (!nCS) ncs_low++;
    if (data_load) begin
      if (dl_cnt == 0) dl_first = cyc;
      dl_cnt++;
    end
    if (read_valid) rv_q.push_back(read_data);
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (err) err_cnt++;
    if (nCS && !p_ncs) rise_cyc = cyc;
    if (!nCS && p_ncs) begin
      s_bits = 0;
      MISO   = 1'b0;
      mosi_q.delete();
    end
    if (!nCS && SCLK && !p_sclk) begin
      if (sclk_first < 0) sclk_first = cyc;
      s_rx = {s_rx[6:0], MOSI};
      s_bits++;
      if (s_bits % 8 == 0) begin
        mosi_q.push_back(s_rx);
        if (s_bits == 8)  s_cmd  = s_rx;
        if (s_bits == 16) s_addr = s_rx;
      end
    end
    if (!nCS && !SCLK && p_sclk) begin
      if (s_bits % 8 == 0) begin
        s_tx = slave_byte(s_bits / 8);
        MISO = s_tx[7];
      end else begin
        MISO = s_tx[7 - (s_bits % 8)];
      end
    end
    p_ncs  = nCS;
    p_sclk = SCLK;
  end

  task automatic start_frame(input logic [7:0] cmd, input logic [5:0] addr, input logic [3:0] cnt);
    @(posedge clk_16mhz); #1;
    command    = cmd;
    address    = addr;
    byte_count = cnt;
    start      = 1'b1;
    @(posedge clk_16mhz); #1;
    start      = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done_cnt == 0 && n < 4000) begin
      @(negedge clk_16mhz); #1;
      n++;
    end
    check(tag, 32'(done_cnt), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] exp_burst [5];
    rst = 1'b1; start = 1'b0; command = 8'h00; address = 6'd0; byte_count = 4'd0;
    for (int i = 0; i < 16; i++) wr_vals[i] = 8'h00;
    repeat (3) @(posedge clk_16mhz);
    #1;
    check("rst_ncs",  32'(nCS),        32'd1);
    check("rst_sclk", 32'(SCLK),       32'd0);
    check("rst_mosi", 32'(MOSI),       32'd0);
    check("rst_busy", 32'(busy),       32'd0);
    check("rst_done", 32'(done),       32'd0);
    check("rst_err",  32'(err),        32'd0);
    check("rst_rv",   32'(read_valid), 32'd0);
    check("rst_rd",   32'(read_data),  32'h00);
    rst = 1'b0;

    // Single register write: 0x02 to 0x2D.
    wr_vals[0] = 8'h02;
    start_frame(8'h0A, 6'h2D, 4'd1);
    check("wr1_c1_ncs",  32'(nCS),  32'd0);
    check("wr1_c1_busy", 32'(busy), 32'd1);
    check("wr1_c1_mosi", 32'(MOSI), 32'd0);
    wait_done("wr1_done");
    check("wr1_busy_at_done", 32'(busy), 32'd0);
    check("wr1_nbytes", 32'(mosi_q.size()), 32'd3);
    check("wr1_b0", 32'(mosi_q[0]), 32'h0A);
    check("wr1_b1", 32'(mosi_q[1]), 32'h2D);
    check("wr1_b2", 32'(mosi_q[2]), 32'h02);
    check("wr1_ncs_low", 32'(ncs_low), 32'd196);
    check("wr1_sclk_first", 32'(sclk_first), 32'(1 + H));
    check("wr1_dl_cnt", 32'(dl_cnt), 32'd1);
    check("wr1_dl_cyc", 32'(dl_first), 32'd0);
    check("wr1_ncs_rise", 32'(rise_cyc), 32'd197);
    check("wr1_gap", 32'(done_cyc - rise_cyc), 32'(GAP));

    // Burst register read of 4 bytes from 0x00, with a start pulse mid-frame.
    start_frame(8'h0B, 6'h00, 4'd4);
    repeat (100) @(posedge clk_16mhz);
    #1;
    command = 8'h0A; start = 1'b1;
    @(posedge clk_16mhz); #1;
    start = 1'b0;
    wait_done("rd4_done");
    check("rd4_nrv", 32'(rv_q.size()), 32'd4);
    check("rd4_d0", 32'(rv_q[0]), 32'hAD);
    check("rd4_d1", 32'(rv_q[1]), 32'h1D);
    check("rd4_d2", 32'(rv_q[2]), 32'hF2);
    check("rd4_d3", 32'(rv_q[3]), 32'h01);
    check("rd4_nbytes", 32'(mosi_q.size()), 32'd6);
    check("rd4_cmd",  32'(mosi_q[0]), 32'h0B);
    check("rd4_addr", 32'(mosi_q[1]), 32'h00);
    for (int i = 2; i < 6; i++) check("rd4_mosi_zero", 32'(mosi_q[i]), 32'h00);
    check("rd4_ncs_low", 32'(ncs_low), 32'(16 * H * 6 + H));
    check("rd4_no_err", 32'(err_cnt), 32'd0);
    check("rd4_no_dl", 32'(dl_cnt), 32'd0);
    check("rd4_last_rd", 32'(read_data), 32'h01);

    // FIFO read with count 0: 16 bytes, no address byte.
    start_frame(8'h0D, 6'h3F, 4'd0);
    wait_done("fifo_done");
    check("fifo_nrv", 32'(rv_q.size()), 32'd16);
    check("fifo_d0",  32'(rv_q[0]),  32'h40);
    check("fifo_d15", 32'(rv_q[15]), 32'h4F);
    check("fifo_nbytes", 32'(mosi_q.size()), 32'd17);
    check("fifo_cmd", 32'(mosi_q[0]), 32'h0D);
    check("fifo_b1",  32'(mosi_q[1]), 32'h00);
    check("fifo_ncs_low", 32'(ncs_low), 32'(16 * H * 17 + H));

    // Burst write of three bytes to 0x20.
    wr_vals[0] = 8'h11; wr_vals[1] = 8'h22; wr_vals[2] = 8'h33;
    exp_burst[0] = 8'h0A; exp_burst[1] = 8'h20;
    exp_burst[2] = 8'h11; exp_burst[3] = 8'h22; exp_burst[4] = 8'h33;
    start_frame(8'h0A, 6'h20, 4'd3);
    wait_done("bw_done");
    check("bw_nbytes", 32'(mosi_q.size()), 32'd5);
    for (int i = 0; i < 5; i++) check("bw_byte", 32'(mosi_q[i]), 32'(exp_burst[i]));
    check("bw_dl_cnt", 32'(dl_cnt), 32'd3);
    check("bw_no_rv", 32'(rv_q.size()), 32'd0);
    check("bw_ncs_low", 32'(ncs_low), 32'(16 * H * 5 + H));

    // Unsupported command.
    start_frame(8'h55, 6'h00, 4'd1);
    check("bad_err_c1", 32'(err),  32'd1);
    check("bad_ncs_c1", 32'(nCS),  32'd1);
    check("bad_busy_c1", 32'(busy), 32'd0);
    @(posedge clk_16mhz); #1;
    check("bad_err_c2", 32'(err),  32'd0);
    check("bad_busy_c2", 32'(busy), 32'd0);
    check("bad_ncs_c2", 32'(nCS),  32'd1);
    check("bad_no_dl", 32'(dl_cnt), 32'd0);

    // Reset during the 5th bit of the address byte, then a clean read.
    start_frame(8'h0B, 6'h00, 4'd1);
    repeat (98) @(posedge clk_16mhz);
    #1;
    check("abort_pre_ncs", 32'(nCS), 32'd0);
    rst = 1'b1;
    @(posedge clk_16mhz); #1;
    check("abort_ncs",  32'(nCS),  32'd1);
    check("abort_sclk", 32'(SCLK), 32'd0);
    check("abort_mosi", 32'(MOSI), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    repeat (20) @(posedge clk_16mhz);
    #1;
    check("abort_no_done", 32'(done_cnt), 32'd0);
    check("abort_no_rv", 32'(rv_q.size()), 32'd0);
    start_frame(8'h0B, 6'h00, 4'd1);
    wait_done("post_rd_done");
    check("post_rd_nrv", 32'(rv_q.size()), 32'd1);
    check("post_rd_d0", 32'(rv_q[0]), 32'hAD);
    check("post_rd_ncs_low", 32'(ncs_low), 32'(16 * H * 3 + H));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
